// File: rtl/text_normalizer_if.sv
// Byte-stream handshake bundle for the text normalizer: raw bytes in, normalized bytes out.
// The "slave" modport is the normalizer side and the "master" modport is the driver/consumer side.
interface text_normalizer_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/text_normalizer.sv
// Normalizes a raw ASCII stream (case fold, whitespace collapse, non-printable drop)
// and buffers the result in a DEPTH-entry FIFO drained one byte per cycle.
module text_normalizer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int CW    = 16
) (
    input  logic                clk,
    input  logic                reset,
    text_normalizer_if.slave    bus,
    output logic [AW:0]         level,
    output logic                drop,
    output logic [CW-1:0]       word_cnt
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    typedef enum logic {
        ST_SPACE = 1'b0,
        ST_WORD  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d;
    logic [7:0]      mem_q [DEPTH];
    logic [7:0]      mem_d [DEPTH];
    logic            drop_q, drop_d;
    logic [CW-1:0]   word_cnt_q, word_cnt_d;

    logic            is_ws, is_alph, is_prn, is_bad;
    logic [7:0]      norm_byte, emit_byte;
    logic            accept, emit, cnt_inc, rd_en;

    // Byte classification of the upstream byte
    always_comb begin
        is_ws     = (bus.in_data == 8'h20) || (bus.in_data == 8'h09) ||
                    (bus.in_data == 8'h0A) || (bus.in_data == 8'h0D);
        is_alph   = (bus.in_data >= 8'h41) && (bus.in_data <= 8'h5A);
        is_prn    = (bus.in_data >= 8'h21) && (bus.in_data <= 8'h7E) && !is_alph;
        is_bad    = !(is_ws || is_alph || is_prn);
        norm_byte = is_alph ? (bus.in_data + 8'h20) : bus.in_data;
    end

    // in_ready looks only at occupancy and reset, never at in_valid
    assign bus.in_ready  = reset && (level_q != FULL_LVL);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (level_q != '0);
    assign bus.out_data  = mem_q[rd_ptr_q];
    assign rd_en         = bus.out_valid && bus.out_ready;

    // Word/space FSM; BAD bytes fall through every branch and leave the state alone
    always_comb begin
        state_d   = state_q;
        emit      = 1'b0;
        emit_byte = norm_byte;
        cnt_inc   = 1'b0;
        if (accept) begin
            case (state_q)
                ST_SPACE: begin
                    if (is_alph || is_prn) begin
                        emit    = 1'b1;
                        cnt_inc = 1'b1;
                        state_d = ST_WORD;
                    end
                end
                ST_WORD: begin
                    if (is_ws) begin
                        emit      = 1'b1;
                        emit_byte = 8'h20;
                        state_d   = ST_SPACE;
                    end else if (is_alph || is_prn) begin
                        emit = 1'b1;
                    end
                end
                default: state_d = ST_SPACE;
            endcase
        end
    end

    // FIFO and counters
    always_comb begin
        mem_d = mem_q;
        if (emit) begin
            mem_d[wr_ptr_q] = emit_byte;
        end
        wr_ptr_d = wr_ptr_q + AW'(emit);
        rd_ptr_d = rd_ptr_q + AW'(rd_en);
        case ({emit, rd_en})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        word_cnt_d = word_cnt_q;
        if (cnt_inc && (word_cnt_q != '1)) begin
            word_cnt_d = word_cnt_q + 1'b1;
        end
        drop_d = accept && is_bad;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_SPACE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            drop_q     <= 1'b0;
            word_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            drop_q     <= drop_d;
            word_cnt_q <= word_cnt_d;
            mem_q      <= mem_d;
        end
    end

    assign level    = level_q;
    assign drop     = drop_q;
    assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_text_normalizer.sv
// Self-checking bench for text_normalizer: directed scenarios plus randomized traffic
// scored against a string-level model of the normalization rules.
module tb_text_normalizer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    text_normalizer_if bus ();
    text_normalizer_if bus2 ();

    logic [3:0]  level;
    logic        drop;
    logic [15:0] word_cnt;
    logic [3:0]  level2;
    logic        drop2;
    logic [1:0]  word_cnt2;

    text_normalizer #(.DEPTH(8), .AW(3), .CW(16)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave),
        .level(level), .drop(drop), .word_cnt(word_cnt)
    );

    text_normalizer #(.DEPTH(8), .AW(3), .CW(2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2.slave),
        .level(level2), .drop(drop2), .word_cnt(word_cnt2)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: state of the text, not of the hardware
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    bit         m_in_word;
    int         m_words;
    int         m_bad;
    int         drop_seen;

    always @(negedge clk) begin
        if (reset && bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
        if (reset && drop) drop_seen++;
    end

    function automatic void model_reset();
        exp_q.delete();
        got_q.delete();
        m_in_word = 0;
        m_words   = 0;
        m_bad     = 0;
        drop_seen = 0;
    endfunction

    function automatic void model_push(input logic [7:0] b);
        if (b == 8'h20 || b == 8'h09 || b == 8'h0A || b == 8'h0D) begin
            if (m_in_word) exp_q.push_back(8'h20);
            m_in_word = 0;
        end else if (b >= 8'h21 && b <= 8'h7E) begin
            if (!m_in_word) m_words++;
            m_in_word = 1;
            exp_q.push_back((b >= "A" && b <= "Z") ? b + 8'd32 : b);
        end else begin
            m_bad++;
        end
    endfunction

    task automatic apply_reset();
        bus.in_valid = 0;
        bus2.in_valid = 0;
        reset = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1;
        @(posedge clk); #1;
        model_reset();
    endtask

    task automatic send(input logic [7:0] b, input bit rnd_rdy);
        int n;
        bit acc;
        n = 0;
        acc = 0;
        bus.in_valid = 1;
        bus.in_data  = b;
        while (!acc && n < 100) begin
            if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
            n++;
        end
        bus.in_valid = 0;
        if (acc) model_push(b);
        else begin
            checks++; errors++;
            $display("FAIL send_timeout byte=%02h never accepted", b);
        end
    endtask

    task automatic send_str(input string s, input bit rnd_rdy);
        for (int i = 0; i < s.len(); i++) send(s[i], rnd_rdy);
    endtask

    task automatic drain_check(input string name);
        int n;
        bus.out_ready = 1;
        n = 0;
        while (got_q.size() < exp_q.size() && n < 300) begin
            @(posedge clk); n++;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL %s_count got=%0d exp=%0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_byte[%0d] got=%02h exp=%02h", name, i, got_q[i], exp_q[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (level !== 4'd0) begin
            errors++;
            $display("FAIL %s_level_empty got=%0d exp=0", name, level);
        end
        @(posedge clk); #1;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0;
        bus2.in_valid = 0; bus2.in_data = 0; bus2.out_ready = 1;
        reset = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid, level, drop, word_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b vld=%b lvl=%0d drop=%b wc=%0d exp all 0",
                     bus.in_ready, bus.out_valid, level, drop, word_cnt);
        end
        reset = 1;
        @(posedge clk); #1;
        model_reset();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got=%b exp=1", bus.in_ready);
        end
    endtask

    task automatic test_basic();
        bus.out_ready = 1;
        drop_seen = 0;
        send_str("  Begin\tEND\n", 0);
        drain_check("basic");
        checks++;
        if (word_cnt !== 16'd2) begin
            errors++; $display("FAIL basic_word_cnt got=%0d exp=2", word_cnt);
        end
        checks++;
        if (drop_seen !== 0) begin
            errors++; $display("FAIL basic_drop got=%0d exp=0", drop_seen);
        end
    endtask

    task automatic test_full();
        bus.out_ready = 0;
        send_str("abcdefgh", 0);
        bus.in_valid = 1;
        bus.in_data  = "i";
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0 || level !== 4'd8) begin
            errors++;
            $display("FAIL full_hold got rdy=%b lvl=%0d exp rdy=0 lvl=8", bus.in_ready, level);
        end
        @(posedge clk); #1;
        bus.out_ready = 1;
        send("i", 0);
        drain_check("full");
    endtask

    task automatic test_drop();
        apply_reset();
        bus.out_ready = 1;
        send("a", 0); send(8'h01, 0); send(8'h7F, 0); send("b", 0);
        drain_check("drop");
        checks++;
        if (drop_seen !== 2) begin
            errors++; $display("FAIL drop_pulses got=%0d exp=2", drop_seen);
        end
        checks++;
        if (word_cnt !== 16'd1) begin
            errors++; $display("FAIL drop_word_cnt got=%0d exp=1", word_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] c;
        bus.out_ready = 0;
        send_str("wxyz", 0);
        bus.out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            c = 8'($urandom_range(8'h61, 8'h7A));
            bus.in_valid = 1;
            bus.in_data  = c;
            @(negedge clk);
            checks++;
            if (level !== 4'd4 || bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_level[%0d] got lvl=%0d rdy=%b exp lvl=4 rdy=1", i, level, bus.in_ready);
            end
            model_push(c);
            @(posedge clk); #1;
        end
        bus.in_valid = 0;
        drain_check("b2b");
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 0;
        send_str("xyz", 0);
        reset = 0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || level !== 4'd0 || word_cnt !== 16'd0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state got vld=%b lvl=%0d wc=%0d rdy=%b exp 0 0 0 0",
                     bus.out_valid, level, word_cnt, bus.in_ready);
        end
        reset = 1;
        @(posedge clk); #1;
        model_reset();
        bus.out_ready = 1;
        send_str(" q", 0);
        drain_check("midreset");
        checks++;
        if (word_cnt !== 16'd1) begin
            errors++; $display("FAIL midreset_word_cnt got=%0d exp=1", word_cnt);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic [7:0] ws_tab [4];
        int r;
        ws_tab[0] = 8'h20; ws_tab[1] = 8'h09; ws_tab[2] = 8'h0A; ws_tab[3] = 8'h0D;
        drop_seen = 0;
        m_bad = 0;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r < 3)      b = ws_tab[$urandom_range(0, 3)];
            else if (r < 5) b = 8'($urandom_range(8'h41, 8'h5A));
            else if (r < 8) b = 8'($urandom_range(8'h21, 8'h7E));
            else            b = 8'($urandom_range(0, 255));
            send(b, 1);
        end
        drain_check("random");
        checks++;
        if (word_cnt !== 16'(m_words)) begin
            errors++; $display("FAIL random_word_cnt got=%0d exp=%0d", word_cnt, m_words);
        end
        checks++;
        if (drop_seen !== m_bad) begin
            errors++; $display("FAIL random_drop got=%0d exp=%0d", drop_seen, m_bad);
        end
    endtask

    task automatic test_saturate();
        string s;
        apply_reset();
        s = "a b c d e";
        bus2.out_ready = 1;
        for (int i = 0; i < s.len(); i++) begin
            bus2.in_valid = 1;
            bus2.in_data  = s[i];
            @(posedge clk); #1;
            if (i == 4) begin
                checks++;
                if (word_cnt2 !== 2'd3) begin
                    errors++; $display("FAIL sat_reach got=%0d exp=3", word_cnt2);
                end
            end
        end
        bus2.in_valid = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (word_cnt2 !== 2'd3 || level2 !== 4'd0 || drop2 !== 1'b0) begin
            errors++;
            $display("FAIL sat_hold got wc=%0d lvl=%0d drop=%b exp wc=3 lvl=0 drop=0",
                     word_cnt2, level2, drop2);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_drop();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
